fibonacci_gen: RTL

Fibonacci sequence generator that sits directly downstream of the Wishbone control slave. It consumes that slave's `switch` (run enable) and `clock_sel` (step-rate select) outputs and drives the current sequence value onto user I/O pads 37:8. The control slave reads the value back over Wishbone for register 0x14. A programmable prescaler paces the steps. On 30-bit overflow the sequence restarts from its seed and the block raises a one-cycle wrap interrupt.

---
 rtl/fibonacci_gen.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/fibonacci_gen.sv
// ---------------------------------------------------------------------------
// fibonacci_gen
//
// Fibonacci sequence generator fed by the Wishbone control slave. While
// running, it steps the sequence once per prescaler period and shows the
// current value on user pads 37:8. When the next value no longer fits in
// VALUE_WIDTH bits, the sequence restarts from its seed (0, 1) and wrap_irq
// pulses for one cycle.
//
// Ports
//   wb_clk_i   in   1            system clock (single clock domain)
//   reset      in   1            synchronous, active-high reset
//   switch     in   1            run enable: 1 = RUN, 0 = PAUSED
//   clock_sel  in   CLOCK_WIDTH  step-period select, lowest set bit k
//                                gives period 2^k; all-zero = no steps
//   io_out     out  VW+8         {current value, 8'h00}
//   io_oeb     out  VW+8         pad output enables (active low), constant
//   fib_index  out  6            index n of the displayed F(n)
//   wrap_irq   out  1            one-cycle pulse when the sequence wraps
// ---------------------------------------------------------------------------
module fibonacci_gen #(
    parameter int CLOCK_WIDTH = 6,
    parameter int VALUE_WIDTH = 30
) (
    input  logic                   wb_clk_i,
    input  logic                   reset,
    input  logic                   switch,
    input  logic [CLOCK_WIDTH-1:0] clock_sel,
    output logic [VALUE_WIDTH+7:0] io_out,
    output logic [VALUE_WIDTH+7:0] io_oeb,
    output logic [5:0]             fib_index,
    output logic                   wrap_irq
);

    typedef enum logic {
        PAUSED = 1'b0,
        RUN    = 1'b1
    } state_t;

    localparam logic [CLOCK_WIDTH-1:0] CNT_ONE = CLOCK_WIDTH'(1);

    state_t                 state;
    logic [VALUE_WIDTH-1:0] a;
    logic [VALUE_WIDTH-1:0] b;
    logic [5:0]             index;
    logic [CLOCK_WIDTH-1:0] cnt;
    logic [CLOCK_WIDTH-1:0] sel_q;

    logic [CLOCK_WIDTH-1:0] period_m1;
    logic                   rate_change;
    logic                   tick;
    logic [VALUE_WIDTH:0]   sum;
    logic                   overflow;

    // Terminal count P-1 for the lowest set bit of clock_sel. Scanning from
    // the top down lets the lowest set bit overwrite any higher one.
    // NOTE: period_m1 gets a default before the loop so that no path leaves
    // it unassigned; otherwise synthesis would infer a latch.
    always_comb begin
        period_m1 = '0;
        for (int i = CLOCK_WIDTH - 1; i >= 0; i--) begin
            if (clock_sel[i]) begin
                period_m1 = CLOCK_WIDTH'((1 << i) - 1);
            end
        end
    end

    // A changed rate restarts the prescaler and suppresses the tick, so a
    // new period always begins from a full count.
    assign rate_change = (clock_sel != sel_q);
    assign tick        = (state == RUN) && (clock_sel != '0) && !rate_change
                         && (cnt == period_m1);

    // One extra bit holds the carry; a set carry marks a sum that no longer
    // fits, and the sequence must restart.
    assign sum      = {1'b0, a} + {1'b0, b};
    assign overflow = sum[VALUE_WIDTH];

    // NOTE: every register here uses non-blocking assignments, so all of
    // them sample the values from before the edge. This matters for the
    // a <= b, b <= a + b swap.
    always_ff @(posedge wb_clk_i) begin
        if (reset) begin
            state    <= PAUSED;
            a        <= '0;
            b        <= VALUE_WIDTH'(1);
            index    <= '0;
            cnt      <= '0;
            sel_q    <= '0;
            wrap_irq <= 1'b0;
        end else begin
            sel_q    <= clock_sel;
            wrap_irq <= 1'b0;

            case (state)
                PAUSED: begin
                    cnt <= '0;
                    if (switch) begin
                        state <= RUN;
                    end
                end

                RUN: begin
                    if (rate_change || (clock_sel == '0) || tick) begin
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end

                    // A step taken on the same edge that switch falls is
                    // kept; the state still drops to PAUSED.
                    if (tick) begin
                        if (overflow) begin
                            a        <= '0;
                            b        <= VALUE_WIDTH'(1);
                            index    <= '0;
                            wrap_irq <= 1'b1;
                        end else begin
                            a     <= b;
                            b     <= sum[VALUE_WIDTH-1:0];
                            index <= index + 6'd1;
                        end
                    end

                    if (!switch) begin
                        state <= PAUSED;
                    end
                end

                default: state <= PAUSED;
            endcase
        end
    end

    // a is already a register, so the pads have no combinational path from
    // any input.
    assign io_out    = {a, 8'h00};
    assign io_oeb    = {{VALUE_WIDTH{1'b0}}, 8'hFF};
    assign fib_index = index;

endmodule
